dac_slew_stage: RTL and testbench
=================================

// Module: dac_slew_stage
// PURPOSE
//  Output stage directly downstream of the PID core: takes its 14-bit offset-binary control word
//  (midscale 8191) and drives the fast DAC code. Clamps the word to programmable rails and limits
//  the slew rate. Ramps smoothly from midscale into lock on enable, and back to midscale on disable.
//  Prevents actuator (piezo/laser current) steps when the loop engages, drops out or railsaturates.
// PARAMETERS
//  DAC_W   14   DAC code width (offset binary)
//  STEP_W  14   width of slew step magnitudes
//  DIV_W   16   width of slew-rate divider
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous, active-low reset
//  enable_i     in   1       loop engaged (same enable that drives the PID core)
//  pid_i        in   DAC_W   PID control word, offset binary
//  lim_lo_i     in   DAC_W   lower output rail
//  lim_hi_i     in   DAC_W   upper output rail
//  step_trk_i   in   STEP_W  max code change per tick in TRACK
//  step_rmp_i   in   STEP_W  max code change per tick in RAMP_IN/RAMP_OUT
//  div_i        in   DIV_W   slew tick every div_i+1 clocks
//  dac_o        out  DAC_W   DAC code; reset 8191
//  state_o      out  2       FSM state encoding; reset IDLE
//  slewing_o    out  1       last tick step was clipped by the step limit; reset 0
//  at_rail_o    out  1       dac_o equals lim_lo or lim_hi while in TRACK; reset 0
//  rail_cnt_o   out  16      saturating count of TRACK ticks with at_rail; only when RAIL_CNT_EN; reset 0
// BEHAVIOUR
//  - All configuration inputs are registered every clock (1-cycle latency).
//  - If lo > hi, hi is treated as lo. A step of 0 is treated as 1.
//  - target_r = clamp(pid_i, lo, hi) is registered. In RAMP_OUT/IDLE the target is 8191 (not clamped).
//  - Tick counter: counts 0..div_r, then wraps. tick = (cnt==div_r); div_r=0 gives a tick every clock.
//    The counter is cleared in IDLE.
//  - On each tick: diff = target_r - dac_r, computed signed at DAC_W+1 bits.
//    - If |diff| <= step: dac_r <= target_r.
//    - Otherwise: dac_r <= dac_r ± step, and slewing_o is set.
//    - The result stays in [0, 2^DAC_W-1] by construction; there is no wrap.
//  - Latency: with no limiting and div=0, a change on pid_i reaches dac_o 2 clocks later.
//  - FSM states: IDLE=0, RAMP_IN=1, TRACK=2, RAMP_OUT=3.
//    - IDLE: dac_o is held at 8191. enable_i=1 -> RAMP_IN.
//    - RAMP_IN: uses step_rmp. On a tick that lands dac_r == target_r -> TRACK. enable_i=0 -> RAMP_OUT.
//    - TRACK: uses step_trk. enable_i=0 -> RAMP_OUT.
//    - RAMP_OUT: uses step_rmp, target 8191. On a tick that reaches 8191 -> IDLE.
//      enable_i=1 -> RAMP_IN, continuing from the current dac_r with no jump.
//  - If enable_i changes and a tick arrive in the same cycle, the tick uses the new state's target and step.
//  - Rails changed during TRACK: the new clamp is applied via slew; there is no instant jump.
//  - Asserting rst_n low mid-ramp immediately forces dac_o=8191, IDLE, and all flags to 0.
// CONFIGURATION
//  RAIL_CNT_EN defined: rail_cnt_o is present. It increments on TRACK ticks while at_rail_o=1,
//    saturates at 16'hFFFF, and clears on entry to RAMP_IN.
//  RAIL_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package pdh_pkg: DAC_W, DAC_MID=14'd8191, and the slew_state_e enum {IDLE, RAMP_IN, TRACK, RAMP_OUT}.
//  Sub-module slew_tick_gen (DIV_W): clear and div inputs, tick output.
//  The FSM, clamp and step logic stay in this module.
// TESTING
//  1. Reset, enable=0, pid=5000 -> dac_o stays 8191, state IDLE.
//  2. lo=0, hi=16383, rmp=100, div=0, pid=9191, enable rises -> dac_o rises by 100 per clock.
//     It reaches 9191 after 10 ticks, state goes to TRACK, slewing_o then drops to 0.
//  3. In TRACK with trk=16383, pid steps 9191 -> 12000 -> dac_o=12000 exactly 2 clocks later.
//  4. hi=10000, pid=12000 -> dac_o slews to 10000 and holds, at_rail_o=1.
//     With RAIL_CNT_EN, rail_cnt_o increments once per tick.
//  5. div=3, rmp=50, enable falls at dac=10000 -> dac_o drops 50 every 4 clocks down to 8191, then IDLE.
//     Re-enable midway -> RAMP_IN from the current code, no discontinuity.
//  6. Edge cases: lo=12000 with hi=11000 -> output clamps to 12000.
//     step=0 -> behaves as 1. rst_n pulsed mid-ramp -> dac_o=8191 asynchronously.

Source files
------------

// File: rtl/pdh_pkg.sv
// ============================================================================
// Module  : pdh_pkg
// Brief   : Shared DAC constants and slew-stage state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pdh_pkg;

    localparam int DAC_W = 14;
    localparam logic [DAC_W-1:0] DAC_MID = 14'd8191;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP_IN  = 2'd1,
        TRACK    = 2'd2,
        RAMP_OUT = 2'd3
    } slew_state_e;

endpackage

`default_nettype wire

// File: rtl/slew_tick_gen.sv
// ============================================================================
// Module  : slew_tick_gen
// Brief   : Slew-rate divider; one tick every div+1 clocks, held off by clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module slew_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // Wrapping on >= keeps the counter bounded if div shrinks mid-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt >= div)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clear && (r_cnt == div);

endmodule

`default_nettype wire

// File: rtl/dac_slew_stage.sv
// ============================================================================
// Module  : dac_slew_stage
// Brief   : Clamps the PID word to rails and slew-limits the DAC code, with
//           smooth ramps in/out of lock. Define RAIL_CNT_EN for rail_cnt_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_slew_stage
    import pdh_pkg::*;
#(
    parameter int DAC_W  = pdh_pkg::DAC_W,
    parameter int STEP_W = 14,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [DAC_W-1:0]  pid_i,
    input  logic [DAC_W-1:0]  lim_lo_i,
    input  logic [DAC_W-1:0]  lim_hi_i,
    input  logic [STEP_W-1:0] step_trk_i,
    input  logic [STEP_W-1:0] step_rmp_i,
    input  logic [DIV_W-1:0]  div_i,
    output logic [DAC_W-1:0]  dac_o,
    output logic [1:0]        state_o,
    output logic              slewing_o,
    output logic              at_rail_o
`ifdef RAIL_CNT_EN
    ,
    output logic [15:0]       rail_cnt_o
`endif
);

    localparam logic [DAC_W-1:0] c_mid = DAC_W'(DAC_MID);

    logic [DAC_W-1:0]  r_lo, r_hi, r_target, r_dac;
    logic [STEP_W-1:0] r_trk, r_rmp;
    logic [DIV_W-1:0]  r_div;
    slew_state_e       r_state;
    logic              r_slewing, r_at_rail;

    logic [DAC_W-1:0]  w_hi, w_clamp, w_target, w_step_d, w_dac_step, w_dac_next;
    logic [STEP_W-1:0] w_step_raw, w_step;
    logic signed [DAC_W:0] w_diff;
    logic [DAC_W:0]    w_mag;
    logic              w_clip, w_tick, w_clear;
    slew_state_e       w_eff, w_state_next;

    assign w_hi    = (r_lo > r_hi) ? r_lo : r_hi;
    assign w_clamp = (pid_i < r_lo) ? r_lo : ((pid_i > w_hi) ? w_hi : pid_i);
    assign w_clear = (r_state == IDLE);

    slew_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .div   (r_div),
        .tick  (w_tick)
    );

    // w_eff reflects enable_i immediately so a coincident tick already uses
    // the new state's target and step size.
    always_comb begin
        w_eff = r_state;
        case (r_state)
            IDLE:          if (enable_i)  w_eff = RAMP_IN;
            RAMP_IN,
            TRACK:         if (!enable_i) w_eff = RAMP_OUT;
            RAMP_OUT:      if (enable_i)  w_eff = RAMP_IN;
            default:       w_eff = r_state;
        endcase
    end

    always_comb begin
        w_target   = ((w_eff == RAMP_OUT) || (w_eff == IDLE)) ? c_mid : r_target;
        w_step_raw = (w_eff == TRACK) ? step_sel_trk() : r_rmp;
        w_step     = (w_step_raw == '0) ? STEP_W'(1) : w_step_raw;
        w_step_d   = DAC_W'(w_step);
        w_diff     = $signed({1'b0, w_target}) - $signed({1'b0, r_dac});
        w_mag      = w_diff[DAC_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_clip     = (w_mag > {1'b0, w_step_d});
        if (!w_clip) begin
            w_dac_step = w_target;
        end else if (w_diff[DAC_W]) begin
            w_dac_step = r_dac - w_step_d;
        end else begin
            w_dac_step = r_dac + w_step_d;
        end
        w_dac_next = w_tick ? w_dac_step : r_dac;

        w_state_next = w_eff;
        if (w_tick) begin
            if ((w_eff == RAMP_IN) && (w_dac_step == w_target)) begin
                w_state_next = TRACK;
            end else if ((w_eff == RAMP_OUT) && (w_dac_step == c_mid)) begin
                w_state_next = IDLE;
            end
        end
    end

    function automatic logic [STEP_W-1:0] step_sel_trk();
        return r_trk;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo      <= '0;
            r_hi      <= '0;
            r_trk     <= '0;
            r_rmp     <= '0;
            r_div     <= '0;
            r_target  <= c_mid;
            r_dac     <= c_mid;
            r_state   <= IDLE;
            r_slewing <= 1'b0;
            r_at_rail <= 1'b0;
        end else begin
            r_lo      <= lim_lo_i;
            r_hi      <= lim_hi_i;
            r_trk     <= step_trk_i;
            r_rmp     <= step_rmp_i;
            r_div     <= div_i;
            r_target  <= w_clamp;
            r_dac     <= w_dac_next;
            r_state   <= w_state_next;
            if (w_tick) begin
                r_slewing <= w_clip;
            end
            r_at_rail <= (w_state_next == TRACK) &&
                         ((w_dac_next == r_lo) || (w_dac_next == w_hi));
        end
    end

`ifdef RAIL_CNT_EN
    logic [15:0] r_rail_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rail_cnt <= '0;
        end else if ((w_state_next == RAMP_IN) && (r_state != RAMP_IN)) begin
            r_rail_cnt <= '0;
        end else if ((r_state == TRACK) && (w_eff == TRACK) && w_tick &&
                     r_at_rail && (r_rail_cnt != 16'hFFFF)) begin
            r_rail_cnt <= r_rail_cnt + 16'd1;
        end
    end

    assign rail_cnt_o = r_rail_cnt;
`endif

    assign dac_o     = r_dac;
    assign state_o   = r_state;
    assign slewing_o = r_slewing;
    assign at_rail_o = r_at_rail;

endmodule

`default_nettype wire

// File: tb/tb_dac_slew_stage.sv
// ============================================================================
// Module  : tb_dac_slew_stage
// Brief   : Directed vector bench for dac_slew_stage (RAIL_CNT_EN optional).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_slew_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [13:0] pid = 14'd5000;
    logic [13:0] lo = 14'd0;
    logic [13:0] hi = 14'd16383;
    logic [13:0] trk = 14'd16383;
    logic [13:0] rmp = 14'd100;
    logic [15:0] div = 16'd0;
    logic [13:0] dac;
    logic [1:0]  state;
    logic        slewing;
    logic        at_rail;
`ifdef RAIL_CNT_EN
    logic [15:0] rail_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dac_slew_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable),
        .pid_i      (pid),
        .lim_lo_i   (lo),
        .lim_hi_i   (hi),
        .step_trk_i (trk),
        .step_rmp_i (rmp),
        .div_i      (div),
        .dac_o      (dac),
        .state_o    (state),
        .slewing_o  (slewing),
        .at_rail_o  (at_rail)
`ifdef RAIL_CNT_EN
        ,
        .rail_cnt_o (rail_cnt)
`endif
    );

    typedef struct {
        int lo;
        int hi;
        int pid;
        int exp_dac;
        int exp_rail;
    } vec_t;

    vec_t vecs[8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int prev;
        int exp;

        vecs[0] = '{12000, 11000,  5000, 12000, 1};
        vecs[1] = '{12000, 11000, 13000, 12000, 1};
        vecs[2] = '{ 1000, 15000,  7000,  7000, 0};
        vecs[3] = '{ 1000, 15000,   200,  1000, 1};
        vecs[4] = '{ 1000, 15000, 16383, 15000, 1};
        vecs[5] = '{    0, 16383,     0,     0, 1};
        vecs[6] = '{    0, 16383, 16383, 16383, 1};
        vecs[7] = '{ 5000,  5000,  9000,  5000, 1};

        // Reset and idle hold
        step(2);
        chk("rst_dac", dac, 8191);
        chk("rst_state", state, 0);
        chk("rst_slew", slewing, 0);
        chk("rst_rail", at_rail, 0);
        rst_n = 1'b1;
        step(3);
        chk("idle_dac", dac, 8191);
        chk("idle_state", state, 0);

        // Ramp in at 100 codes per clock
        pid = 14'd9191;
        step(2);
        enable = 1'b1;
        step(1);
        chk("rin_state0", state, 1);
        chk("rin_dac0", dac, 8191);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("rin_dac", dac, 8191 + 100 * k);
            chk("rin_state", state, (k == 10) ? 2 : 1);
            chk("rin_slew", slewing, (k == 10) ? 0 : 1);
        end

        // Two-clock latency in TRACK
        pid = 14'd12000;
        step(1);
        chk("lat_dac1", dac, 9191);
        step(1);
        chk("lat_dac2", dac, 12000);
        chk("lat_slew", slewing, 0);

        // Rail lowered in TRACK: slew down and hold
        hi = 14'd10000;
        trk = 14'd500;
        step(2);
        chk("rail_hold", dac, 12000);
        step(1);
        chk("rail_s1", dac, 11500);
        chk("rail_slew1", slewing, 1);
        step(2);
        chk("rail_s3", dac, 10500);
        step(1);
        chk("rail_land", dac, 10000);
        chk("rail_flag", at_rail, 1);
        chk("rail_slew0", slewing, 0);
        chk("rail_state", state, 2);
`ifdef RAIL_CNT_EN
        chk("rcnt0", rail_cnt, 0);
`endif
        step(1);
        chk("rail_keep", dac, 10000);
`ifdef RAIL_CNT_EN
        chk("rcnt1", rail_cnt, 1);
        step(1);
        chk("rcnt2", rail_cnt, 2);
`endif

        // Ramp out with div=3, re-enable midway
        rmp = 14'd50;
        div = 16'd3;
        step(6);
        chk("rout_pre", dac, 10000);
        enable = 1'b0;
        step(1);
        chk("rout_state", state, 3);
        guard = 0;
        while (dac == 14'd10000 && guard < 8) begin
            step(1);
            guard++;
        end
        chk("rout_first", dac, 9950);
        step(3);
        chk("rout_hold", dac, 9950);
        step(1);
        chk("rout_second", dac, 9900);
        enable = 1'b1;
        step(1);
        chk("rre_state", state, 1);
        chk("rre_nojump", dac, 9900);
        step(3);
        chk("rre_up", dac, 9950);
        step(4);
        chk("rre_land", dac, 10000);
        chk("rre_track", state, 2);
        enable = 1'b0;
        prev = 10000;
        guard = 0;
        while (state != 2'd0 && guard < 250) begin
            step(1);
            guard++;
            if (int'(dac) != prev) begin
                exp = (prev - 50 < 8191) ? 8191 : prev - 50;
                chk("rout_step", dac, exp);
                prev = dac;
            end
        end
        chk("rout_idle", state, 0);
        chk("rout_mid", dac, 8191);
        chk("rout_slew", slewing, 0);

        // Inverted rails, then table of clamp vectors in TRACK
        lo = 14'd12000;
        hi = 14'd11000;
        pid = 14'd5000;
        rmp = 14'd16383;
        trk = 14'd16383;
        div = 16'd0;
        step(2);
        enable = 1'b1;
        step(2);
        chk("inv_dac", dac, 12000);
        chk("inv_state", state, 2);
        for (int i = 0; i < 8; i++) begin
            lo  = 14'(vecs[i].lo);
            hi  = 14'(vecs[i].hi);
            pid = 14'(vecs[i].pid);
            step(3);
            chk("vec_dac", dac, vecs[i].exp_dac);
            chk("vec_rail", at_rail, vecs[i].exp_rail);
            chk("vec_state", state, 2);
        end

        // Step of zero acts as one
        lo = 14'd0;
        hi = 14'd16383;
        trk = 14'd0;
        pid = 14'd5003;
        step(2);
        chk("s0_hold", dac, 5000);
        step(1);
        chk("s0_1", dac, 5001);
        chk("s0_slew", slewing, 1);
        step(1);
        chk("s0_2", dac, 5002);
        step(1);
        chk("s0_3", dac, 5003);
        chk("s0_slew_end", slewing, 0);

        // Asynchronous reset mid-ramp
        rmp = 14'd1;
        step(1);
        enable = 1'b0;
        step(5);
        chk("mid_dac", dac, 5008);
        chk("mid_state", state, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac", dac, 8191);
        chk("arst_state", state, 0);
        chk("arst_slew", slewing, 0);
        chk("arst_rail", at_rail, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("post_dac", dac, 8191);
        chk("post_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
